// File: rtl/k6502_pkg.sv
// rtl/k6502_pkg.sv - shared types, opcode constants and decode helpers for the k6502 timing/decode stage
package k6502_pkg;

  typedef struct packed {
    logic add_adl;
    logic add_sb_6_0;
    logic add_sb_7;
    logic adh_abh;
    logic adl_abl;
    logic dl_adh;
    logic dl_adl;
    logic dl_db;
    logic sb_x;
    logic sb_y;
    logic x_sb;
    logic y_sb;
    logic sb_db;
  } control_signals_t;

  typedef enum logic [2:0] {RST, VEC_L, VEC_H, T1, T2, T3, T4, JAM} tstate_t;

  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_LDX_ABS = 8'hAE;
  localparam logic [7:0] OP_LDY_ABS = 8'hAC;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  // One decode-ROM word: datapath enables plus sequencing hints for the timing FSM.
  typedef struct packed {
    control_signals_t ctrl;
    logic pc_adl;
    logic pc_adh;
    logic pc_inc;
    logic adl_pcl;
    logic adh_pch;
    logic vec_adl;
    logic vec_hi;
    logic vec_adh;
    logic alu_pass;
    logic sync;
    logic done;
    logic addr_from_add;
    logic set_wb_x;
    logic set_wb_y;
  } rom_word_t;

  function automatic logic is_impl(input logic [7:0] op);
    return op inside {OP_LDX_IMM, OP_LDY_IMM, OP_LDX_ABS, OP_LDY_ABS, OP_JMP_ABS, OP_NOP};
  endfunction

endpackage

// File: rtl/k6502_decode_rom.sv
// rtl/k6502_decode_rom.sv - combinational (IR, T-state) to control word decode
module k6502_decode_rom
  import k6502_pkg::*;
(
  input  logic [7:0] ir,
  input  tstate_t    tstate,
  input  logic       t1_add,
  input  logic       wb_x,
  input  logic       wb_y,
  output rom_word_t  w
);

  always_comb begin
    w = '0;
    unique case (tstate)
      VEC_L: begin
        w.vec_adl      = 1'b1;
        w.vec_adh      = 1'b1;
        w.ctrl.adl_abl = 1'b1;
        w.ctrl.adh_abh = 1'b1;
      end
      VEC_H: begin
        w.vec_adl       = 1'b1;
        w.vec_hi        = 1'b1;
        w.vec_adh       = 1'b1;
        w.ctrl.adl_abl  = 1'b1;
        w.ctrl.adh_abh  = 1'b1;
        w.ctrl.dl_db    = 1'b1;
        w.alu_pass      = 1'b1;
        w.done          = 1'b1;
        w.addr_from_add = 1'b1;
      end
      T1: begin
        w.ctrl.adl_abl = 1'b1;
        w.ctrl.adh_abh = 1'b1;
        w.pc_inc       = 1'b1;
        w.sync         = 1'b1;
        // Jump/vector target: ADD holds the low byte, DL the high byte.
        if (t1_add) begin
          w.ctrl.add_adl = 1'b1;
          w.ctrl.dl_adh  = 1'b1;
          w.adl_pcl      = 1'b1;
          w.adh_pch      = 1'b1;
        end else begin
          w.pc_adl = 1'b1;
          w.pc_adh = 1'b1;
        end
        if (wb_x || wb_y) begin
          w.ctrl.dl_db = 1'b1;
          w.ctrl.sb_db = 1'b1;
        end
        w.ctrl.sb_x = wb_x;
        w.ctrl.sb_y = wb_y;
      end
      T2: begin
        w.pc_adl       = 1'b1;
        w.pc_adh       = 1'b1;
        w.ctrl.adl_abl = 1'b1;
        w.ctrl.adh_abh = 1'b1;
        case (ir)
          OP_LDX_IMM: begin w.pc_inc = 1'b1; w.done = 1'b1; w.set_wb_x = 1'b1; end
          OP_LDY_IMM: begin w.pc_inc = 1'b1; w.done = 1'b1; w.set_wb_y = 1'b1; end
          OP_LDX_ABS, OP_LDY_ABS, OP_JMP_ABS: w.pc_inc = 1'b1;
          default: w.done = 1'b1;
        endcase
      end
      T3: begin
        w.pc_adl       = 1'b1;
        w.pc_adh       = 1'b1;
        w.ctrl.adl_abl = 1'b1;
        w.ctrl.adh_abh = 1'b1;
        w.ctrl.dl_db   = 1'b1;
        w.alu_pass     = 1'b1;
        if (ir == OP_JMP_ABS) begin
          w.done          = 1'b1;
          w.addr_from_add = 1'b1;
        end else begin
          w.pc_inc = 1'b1;
        end
      end
      T4: begin
        w.ctrl.add_adl = 1'b1;
        w.ctrl.dl_adh  = 1'b1;
        w.ctrl.adl_abl = 1'b1;
        w.ctrl.adh_abh = 1'b1;
        w.done         = 1'b1;
        w.set_wb_x     = (ir == OP_LDX_ABS);
        w.set_wb_y     = (ir == OP_LDY_ABS);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/k6502_timing_decode.sv
// rtl/k6502_timing_decode.sv - IR, T-state timing FSM and reset-vector sequencer
// Optional: define K6502_ILLEGAL_JAM_EN to halt in JAM on unimplemented opcodes.
module k6502_timing_decode
  import k6502_pkg::*;
#(
  parameter int         RST_DEAD_CYCLES = 5,
  parameter logic [7:0] VEC_ADL_LO      = 8'hFC
) (
  input  logic             ph0,
  input  logic             reset_n,
  input  logic [7:0]       pd_in,
  output control_signals_t ctrl,
  output logic             pc_adl,
  output logic             pc_adh,
  output logic             pc_inc,
  output logic             adl_pcl,
  output logic             adh_pch,
  output logic             vec_adl,
  output logic             vec_hi,
  output logic             vec_adh,
  output logic             alu_pass,
  output logic             sync,
  output logic             illegal
);

  localparam logic [2:0] DEAD_LAST = 3'(RST_DEAD_CYCLES - 1);

  tstate_t    state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] ir, ir_nx;
  logic       wb_x, wb_x_nx, wb_y, wb_y_nx;
  logic       t1_add, t1_add_nx;
  logic       illegal_q, illegal_nx;
  rom_word_t  w;

  k6502_decode_rom u_rom (
    .ir     (ir),
    .tstate (state),
    .t1_add (t1_add),
    .wb_x   (wb_x),
    .wb_y   (wb_y),
    .w      (w)
  );

  always_ff @(posedge ph0 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RST;
      cnt       <= '0;
      ir        <= OP_NOP;
      wb_x      <= 1'b0;
      wb_y      <= 1'b0;
      t1_add    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ir        <= ir_nx;
      wb_x      <= wb_x_nx;
      wb_y      <= wb_y_nx;
      t1_add    <= t1_add_nx;
      illegal_q <= illegal_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ir_nx      = ir;
    wb_x_nx    = wb_x;
    wb_y_nx    = wb_y;
    t1_add_nx  = t1_add;
    illegal_nx = illegal_q;
    case (state)
      RST: begin
        if (cnt == DEAD_LAST) begin
          state_nx = VEC_L;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      VEC_L: state_nx = VEC_H;
      VEC_H: state_nx = T1;
      T1: begin
        ir_nx     = pd_in;
        wb_x_nx   = 1'b0;
        wb_y_nx   = 1'b0;
        t1_add_nx = 1'b0;
        state_nx  = T2;
        if (!is_impl(pd_in)) begin
          illegal_nx = 1'b1;
`ifdef K6502_ILLEGAL_JAM_EN
          state_nx = JAM;
`endif
        end
      end
      T2: state_nx = w.done ? T1 : T3;
      T3: state_nx = w.done ? T1 : T4;
      T4: state_nx = T1;
      JAM: state_nx = JAM;
      default: state_nx = RST;
    endcase
    // The last cycle of an instruction arms what the overlapping fetch must do.
    if (w.done) begin
      t1_add_nx = w.addr_from_add;
      wb_x_nx   = w.set_wb_x;
      wb_y_nx   = w.set_wb_y;
    end
  end

  assign ctrl     = w.ctrl;
  assign pc_adl   = w.pc_adl;
  assign pc_adh   = w.pc_adh;
  assign pc_inc   = w.pc_inc;
  assign adl_pcl  = w.adl_pcl;
  assign adh_pch  = w.adh_pch;
  assign vec_adl  = w.vec_adl;
  assign vec_hi   = w.vec_hi;
  assign vec_adh  = w.vec_adh;
  assign alu_pass = w.alu_pass;
  assign sync     = w.sync;
  assign illegal  = illegal_q;

  a_adl_single_driver: assert property (@(posedge ph0) disable iff (!reset_n)
    !(pc_adl && (ctrl.add_adl || ctrl.dl_adl || vec_adl)));

  a_param_range: assert property (@(posedge ph0)
    (RST_DEAD_CYCLES >= 1) && (RST_DEAD_CYCLES <= 7) && (VEC_ADL_LO != 8'hFF));

endmodule

// File: doc/k6502_timing_decode.md
Name: k6502_timing_decode

Overview:
- Upstream control stage of the k6502 datapath: holds the instruction register (IR) and the T-state timing counter, and drives the per-cycle control bundle consumed by the register/bus datapath (address-bus latches, index registers, input data latch, adder hold register).
- Also sequences the reset vector fetch and emits SYNC on opcode-fetch cycles.
- First cut implements a bring-up instruction subset; all other opcodes are handled as described under Behaviour.

Parameters:
- RST_DEAD_CYCLES, 5, idle cycles after reset release before the vector fetch (range 1..7).
- VEC_ADL_LO, 8'hFC, low byte of the reset-vector low address; high-byte fetch uses VEC_ADL_LO+1.

Ports:
- ph0  input  1  CPU cycle clock; one rising edge per machine cycle.
- reset_n  input  1  asynchronous active-low reset.
- pd_in  input  8  pre-decode register output; the opcode is valid at the end of a fetch cycle.
- ctrl  output  control_signals_t  datapath bus/load enables (bundle defined in package).
- pc_adl / pc_adh  output  1 each  PC low/high drives ADL/ADH.
- pc_inc  output  1  increment PC at end of cycle.
- adl_pcl / adh_pch  output  1 each  load PCL/PCH from ADL/ADH.
- vec_adl  output  1  drive vector low byte onto ADL.
- vec_hi  output  1  selects VEC_ADL_LO+1 when vec_adl=1.
- vec_adh  output  1  drive 8'hFF onto ADH.
- alu_pass  output  1  ALU passes DB through to ADD.
- sync  output  1  opcode-fetch cycle.
- illegal  output  1  sticky: an unimplemented opcode was decoded.

Behaviour:
- Reset (async, reset_n=0):
  - state=RST, counter=0, IR=8'hEA.
  - All outputs 0, including every ctrl field.
  - pending writeback cleared; illegal cleared.
- Reset mid-instruction aborts immediately with no further enables.
- Reset sequence:
  - After release: RST_DEAD_CYCLES idle cycles.
  - VEC_L: vec_adl, vec_adh, adl_abl, adh_abh asserted.
  - VEC_H: vec_adl, vec_hi, vec_adh, adl_abl, adh_abh, dl_db, alu_pass asserted.
  - Next cycle (FETCH): add_adl, adl_pcl, dl_adh, adh_pch, adl_abl, adh_abh, pc_inc, sync. This cycle is T1 of the first instruction.
- Normal T1 (FETCH): pc_adl, pc_adh, adl_abl, adh_abh, pc_inc, sync. IR <= pd_in at end of cycle.
- Pending writeback overlaps T1: dl_db, sb_db, and sb_x or sb_y, asserted in the same cycle as the next fetch.
- Subset and cycle counts:
  - LDX# A2 / LDY# A0, 2 cycles:
    - T2: PC fetch + pc_inc.
    - Sets pending writeback X or Y.
  - LDX abs AE / LDY abs AC, 4 cycles:
    - T2: fetch lo, pc_inc.
    - T3: fetch hi, pc_inc, dl_db + alu_pass (lo byte goes to ADD).
    - T4: add_adl, dl_adh, adl_abl, adh_abh.
    - Writeback on the following T1.
  - JMP abs 4C, 3 cycles:
    - T2 as above.
    - T3: fetch hi, dl_db + alu_pass.
    - Next T1 uses ADD/DL for the address: add_adl, dl_adh, adl_pcl, adh_pch, adl_abl, adh_abh, pc_inc, sync. Same path as the vector load.
  - NOP EA, 2 cycles: T2 is a dummy read at PC, no pc_inc.
  - TXY-style copies: not implemented. x_sb/y_sb are reserved 0.
- Unimplemented opcode: illegal<=1 (sticky until reset); execute as 2-cycle NOP.
- Mutual exclusion: at most one driver per bus per cycle. Assertion: pc_adl & (add_adl|dl_adl|vec_adl) never true.
- T-counter wraps to T1 only via decode completion; no free-running wrap.

Optional Feature:
- Macro K6502_ILLEGAL_JAM_EN.
- Defined: an unimplemented opcode enters state JAM.
  - All outputs 0 except illegal=1.
  - sync stays 0.
  - Only reset_n exits JAM.
- Undefined: 2-cycle NOP behaviour as above.

Decomposition:
- Package k6502_pkg holds:
  - control_signals_t fields: add_adl, add_sb_6_0, add_sb_7, adh_abh, adl_abl, dl_adh, dl_adl, dl_db, sb_x, sb_y, x_sb, y_sb, sb_db.
  - Opcode constants OP_LDX_IMM, OP_LDY_IMM, OP_LDX_ABS, OP_LDY_ABS, OP_JMP_ABS, OP_NOP.
  - tstate_t enum: RST, VEC_L, VEC_H, T1..T4, JAM.
- Sub-module k6502_decode_rom: combinational (IR, tstate) -> control word. The timing FSM stays in the top of this block.

Test Plan:
- Reset release, RST_DEAD_CYCLES=5:
  - Cycle 6: VEC_L with vec_adl=1, vec_hi=0.
  - Cycle 7: vec_hi=1.
  - Cycle 8: sync=1 with adl_pcl=adh_pch=1.
- Opcode stream A2,55: sync on cycles 0 and 2; sb_x=1, dl_db=1 in cycle 2 coincident with the next fetch.
- AE,34,12 then EA:
  - T3 alu_pass=1.
  - T4 add_adl=dl_adh=adl_abl=1.
  - Next T1 sb_x=1.
  - Fetch period 4 cycles.
- 4C,00,80: third cycle after opcode has sync=1, adl_pcl=1, add_adl=1; period 3 cycles.
- Opcode 02:
  - Without macro: illegal=1 and sync again 2 cycles later.
  - With K6502_ILLEGAL_JAM_EN: sync stays 0 for 20 cycles until reset_n pulses.
- reset_n=0 asserted during T3 of AC: all outputs 0 in the same cycle asynchronously; after release the vector sequence restarts and illegal=0.
